// File: rtl/inst_fetch_pkg.sv
//--------------------------------------------------------------------
// inst_fetch_pkg: shared constants, FSM states and queue entry type.
// Revision 1.0
//--------------------------------------------------------------------
`default_nettype none

package inst_fetch_pkg;

  localparam logic RstEnable   = 1'b1;
  localparam logic ChipEnable  = 1'b1;
  localparam logic ChipDisable = 1'b0;
  localparam logic [31:0] ZeroWord = 32'h0000_0000;
  localparam int InstAddrBus = 32;
  localparam int InstBus     = 32;

  typedef enum logic [0:0] {
    IfStateIdle = 1'b0,
    IfStateRun  = 1'b1
  } if_state_e;

  typedef struct packed {
    logic [InstAddrBus-1:0] pc;
    logic [InstBus-1:0]     inst;
  } fetch_entry_t;

endpackage

`default_nettype wire

// File: rtl/inst_fetch_if.sv
//--------------------------------------------------------------------
// inst_fetch_if: control, ROM and IF/ID signals of the fetch unit.
// Revision 1.0
//--------------------------------------------------------------------
`default_nettype none

interface inst_fetch_if;
  import inst_fetch_pkg::*;

  logic                   stall_i;
  logic                   flush_i;
  logic [InstAddrBus-1:0] new_pc_i;
  logic                   branch_flag_i;
  logic [InstAddrBus-1:0] branch_target_address_i;
  logic                   rom_ce_o;
  logic [InstAddrBus-1:0] rom_addr_o;
  logic [InstBus-1:0]     rom_inst_i;
  logic                   if_valid_o;
  logic [InstAddrBus-1:0] if_pc_o;
  logic [InstBus-1:0]     if_inst_o;

  modport master (
    input  stall_i, flush_i, new_pc_i, branch_flag_i, branch_target_address_i, rom_inst_i,
    output rom_ce_o, rom_addr_o, if_valid_o, if_pc_o, if_inst_o
  );

  modport slave (
    output stall_i, flush_i, new_pc_i, branch_flag_i, branch_target_address_i, rom_inst_i,
    input  rom_ce_o, rom_addr_o, if_valid_o, if_pc_o, if_inst_o
  );

endinterface

`default_nettype wire

// File: rtl/inst_fetch_q.sv
//--------------------------------------------------------------------
// inst_fetch_q: two-entry prefetch FIFO with clear; head is registered.
// Revision 1.0
//--------------------------------------------------------------------
`default_nettype none

module inst_fetch_q
  import inst_fetch_pkg::*;
(
  input  wire logic         clk,
  input  wire logic         rst,
  input  wire logic         clear,
  input  wire logic         push,
  input  wire logic         pop,
  input  wire fetch_entry_t din,
  output fetch_entry_t      head,
  output logic [1:0]        count
);

  fetch_entry_t tail;

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      head  <= '{pc: ZeroWord, inst: ZeroWord};
      tail  <= '{pc: ZeroWord, inst: ZeroWord};
      count <= 2'd0;
    end else if (clear) begin
      count <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) head <= din;
          else               tail <= din;
          if (count != 2'd2) count <= count + 2'd1;
        end
        2'b01: begin
          head <= tail;
          if (count != 2'd0) count <= count - 2'd1;
        end
        2'b11: begin
          // Simultaneous push/pop: the new word lands behind whatever survives the pop.
          if (count == 2'd2) begin
            head <= tail;
            tail <= din;
          end else begin
            head <= din;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/inst_fetch.sv
//--------------------------------------------------------------------
// inst_fetch: fetch PC/FSM with delay-slot branch, flush and prefetch queue.
// Revision 1.0
//--------------------------------------------------------------------
`default_nettype none

module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input wire logic     clk,
  input wire logic     rst,
  inst_fetch_if.master bus
);

  localparam logic [1:0] Q_DEPTH = DEPTH[1:0];

  if_state_e              state;
  logic                   rom_ce;
  logic [InstAddrBus-1:0] pc;
  fetch_entry_t           head;
  logic [1:0]             count;

  logic valid, pop, push, take_branch, q_clear, q_push, q_pop;

  always_comb begin
    valid       = (count != 2'd0);
    pop         = valid && !bus.stall_i;
    push        = (state == IfStateRun) && (rom_ce == ChipEnable) && ((count < Q_DEPTH) || pop);
    take_branch = bus.branch_flag_i && !bus.stall_i && !bus.flush_i;
    // A branch with a non-empty queue: the head leaves as the delay slot, the rest is wrong-path.
    q_clear     = bus.flush_i || (take_branch && valid);
    q_push      = push && !q_clear;
    q_pop       = pop && !q_clear;
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state  <= IfStateIdle;
      rom_ce <= ChipDisable;
      pc     <= RESET_PC;
    end else begin
      case (state)
        IfStateIdle: begin
          state  <= IfStateRun;
          rom_ce <= ChipEnable;
        end
        default: begin
          state  <= IfStateRun;
          rom_ce <= ChipEnable;
        end
      endcase
      if (bus.flush_i)       pc <= bus.new_pc_i;
      else if (take_branch)  pc <= bus.branch_target_address_i;
      else if (push)         pc <= pc + 32'd4;
    end
  end

  inst_fetch_q u_q (
    .clk   (clk),
    .rst   (rst),
    .clear (q_clear),
    .push  (q_push),
    .pop   (q_pop),
    .din   ('{pc: pc, inst: bus.rom_inst_i}),
    .head  (head),
    .count (count)
  );

  assign bus.rom_ce_o   = rom_ce;
  assign bus.rom_addr_o = pc;
  assign bus.if_valid_o = valid;
  assign bus.if_pc_o    = head.pc;
  assign bus.if_inst_o  = head.inst;

endmodule

`default_nettype wire

// File: tb/tb_inst_fetch.sv
//--------------------------------------------------------------------
// tb_inst_fetch: directed scenarios plus randomized run against a queue model.
// Revision 1.0
//--------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_inst_fetch;
  import inst_fetch_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  inst_fetch_if bus();

  inst_fetch #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  assign bus.rom_inst_i = bus.rom_addr_o ^ 32'hA5A5_0000;

  int checks = 0;
  int errors = 0;

  // Reference: queue of {pc, inst} words, next fetch address, running flag.
  logic [63:0] mq[$];
  logic [31:0] mpc = 32'h0;
  bit          mrun = 1'b0;
  bit          mce = 1'b0;

  task automatic cycle(input bit r, input bit s, input bit f, input logic [31:0] npc,
                       input bit b, input logic [31:0] tgt);
    bit pop, push;
    logic [63:0] ent;
    rst = r; bus.stall_i = s; bus.flush_i = f; bus.new_pc_i = npc;
    bus.branch_flag_i = b; bus.branch_target_address_i = tgt;
    ent  = {mpc, mpc ^ 32'hA5A5_0000};
    pop  = (mq.size() > 0) && !s;
    push = mrun && mce && ((mq.size() < 2) || pop);
    if (r) begin
      mq.delete(); mpc = 32'h0; mrun = 1'b0; mce = 1'b0;
    end else begin
      if (f) begin
        mq.delete(); mpc = npc;
      end else if (b && !s) begin
        if (mq.size() > 0) mq.delete();
        else if (push) mq.push_back(ent);
        mpc = tgt;
      end else begin
        if (pop) void'(mq.pop_front());
        if (push) begin mq.push_back(ent); mpc = mpc + 32'd4; end
      end
      mrun = 1'b1; mce = 1'b1;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    cycle(1, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0);
    checks++;
    if (bus.if_valid_o !== 1'b0 || bus.if_pc_o !== 32'h0 || bus.if_inst_o !== 32'h0 ||
        bus.rom_ce_o !== 1'b0 || bus.rom_addr_o !== 32'h0) begin
      errors++;
      $display("FAIL reset: valid=%b pc=%h inst=%h ce=%b addr=%h, expected all zero",
               bus.if_valid_o, bus.if_pc_o, bus.if_inst_o, bus.rom_ce_o, bus.rom_addr_o);
    end
  endtask

  task automatic test_stream();
    cycle(0, 0, 0, 0, 0, 0);
    checks++;
    if (bus.rom_ce_o !== 1'b1 || bus.if_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL stream_e1: ce=%b valid=%b, expected ce=1 valid=0", bus.rom_ce_o, bus.if_valid_o);
    end
    for (int i = 0; i < 12; i++) begin
      cycle(0, 0, 0, 0, 0, 0);
      checks++;
      if (bus.if_valid_o !== 1'b1 || bus.if_pc_o !== 32'(i * 4) ||
          bus.if_inst_o !== (32'(i * 4) ^ 32'hA5A5_0000)) begin
        errors++;
        $display("FAIL stream %0d: valid=%b pc=%h inst=%h, expected valid=1 pc=%h inst=%h", i,
                 bus.if_valid_o, bus.if_pc_o, bus.if_inst_o, 32'(i * 4), 32'(i * 4) ^ 32'hA5A5_0000);
      end
    end
  endtask

  task automatic run_until_head(input logic [31:0] want);
    for (int i = 0; i < 40 && !(mq.size() != 0 && mq[0][63:32] == want); i++) cycle(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_stall();
    cycle(1, 0, 0, 0, 0, 0);
    run_until_head(32'h10);
    for (int i = 0; i < 4; i++) cycle(0, 1, 0, 0, 0, 0);
    checks++;
    if (bus.if_valid_o !== 1'b1 || bus.if_pc_o !== 32'h10 || bus.rom_addr_o !== 32'h18) begin
      errors++;
      $display("FAIL stall_hold: valid=%b head=%h addr=%h, expected 1 00000010 00000018",
               bus.if_valid_o, bus.if_pc_o, bus.rom_addr_o);
    end
    for (int i = 1; i <= 2; i++) begin
      cycle(0, 0, 0, 0, 0, 0);
      checks++;
      if (bus.if_valid_o !== 1'b1 || bus.if_pc_o !== 32'(16 + 4 * i)) begin
        errors++;
        $display("FAIL stall_release %0d: valid=%b head=%h, expected 1 %h", i,
                 bus.if_valid_o, bus.if_pc_o, 32'(16 + 4 * i));
      end
    end
  endtask

  task automatic test_branch_full();
    cycle(1, 0, 0, 0, 0, 0);
    run_until_head(32'h24);
    cycle(0, 1, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 1, 32'h100);
    checks++;
    if (bus.if_valid_o !== 1'b0 || bus.rom_addr_o !== 32'h100) begin
      errors++;
      $display("FAIL branch_full_drop: valid=%b addr=%h, expected 0 00000100", bus.if_valid_o, bus.rom_addr_o);
    end
    cycle(0, 0, 0, 0, 0, 0);
    checks++;
    if (bus.if_valid_o !== 1'b1 || bus.if_pc_o !== 32'h100 || bus.if_inst_o !== 32'hA5A5_0100) begin
      errors++;
      $display("FAIL branch_full_target: valid=%b pc=%h inst=%h, expected 1 00000100 a5a50100",
               bus.if_valid_o, bus.if_pc_o, bus.if_inst_o);
    end
  endtask

  task automatic test_branch_empty();
    cycle(0, 0, 1, 32'h1C0, 0, 0);
    cycle(0, 0, 0, 0, 1, 32'h200);
    checks++;
    if (bus.if_valid_o !== 1'b1 || bus.if_pc_o !== 32'h1C0 || bus.rom_addr_o !== 32'h200) begin
      errors++;
      $display("FAIL branch_empty_slot: valid=%b pc=%h addr=%h, expected 1 000001c0 00000200",
               bus.if_valid_o, bus.if_pc_o, bus.rom_addr_o);
    end
    cycle(0, 0, 0, 0, 0, 0);
    checks++;
    if (bus.if_valid_o !== 1'b1 || bus.if_pc_o !== 32'h200) begin
      errors++;
      $display("FAIL branch_empty_target: valid=%b pc=%h, expected 1 00000200", bus.if_valid_o, bus.if_pc_o);
    end
  endtask

  task automatic test_branch_stalled();
    for (int i = 0; i < 3; i++) begin
      cycle(0, 1, 0, 0, 1, 32'h300);
      checks++;
      if (bus.rom_addr_o === 32'h300) begin
        errors++;
        $display("FAIL branch_stalled %0d: addr=%h, expected anything but 00000300", i, bus.rom_addr_o);
      end
    end
    cycle(0, 0, 0, 0, 1, 32'h300);
    checks++;
    if (bus.rom_addr_o !== 32'h300 || bus.rom_addr_o !== mpc) begin
      errors++;
      $display("FAIL branch_unstalled: addr=%h, expected 00000300", bus.rom_addr_o);
    end
  endtask

  task automatic test_flush();
    cycle(0, 0, 1, 32'h180, 1, 32'h400);
    checks++;
    if (bus.if_valid_o !== 1'b0 || bus.rom_addr_o !== 32'h180) begin
      errors++;
      $display("FAIL flush_clear: valid=%b addr=%h, expected 0 00000180", bus.if_valid_o, bus.rom_addr_o);
    end
    cycle(0, 0, 0, 0, 0, 0);
    checks++;
    if (bus.if_valid_o !== 1'b1 || bus.if_pc_o !== 32'h180) begin
      errors++;
      $display("FAIL flush_target: valid=%b pc=%h, expected 1 00000180", bus.if_valid_o, bus.if_pc_o);
    end
    cycle(0, 0, 1, 32'hFFFF_FFF8, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
    checks++;
    if (bus.rom_addr_o !== 32'h0 || bus.if_pc_o !== 32'hFFFF_FFFC) begin
      errors++;
      $display("FAIL pc_wrap: addr=%h head=%h, expected 00000000 fffffffc", bus.rom_addr_o, bus.if_pc_o);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) cycle(0, i == 1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0);
    checks++;
    if (bus.if_valid_o !== 1'b0 || bus.if_pc_o !== 32'h0 || bus.if_inst_o !== 32'h0 ||
        bus.rom_ce_o !== 1'b0 || bus.rom_addr_o !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid: valid=%b pc=%h inst=%h ce=%b addr=%h, expected all zero",
               bus.if_valid_o, bus.if_pc_o, bus.if_inst_o, bus.rom_ce_o, bus.rom_addr_o);
    end
  endtask

  task automatic test_random();
    bit r, s, f, b;
    logic [31:0] npc, tgt;
    cycle(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 400; i++) begin
      r = ($urandom % 60) == 0;
      s = ($urandom % 10) < 4;
      f = ($urandom % 25) == 0;
      b = ($urandom % 8) == 0;
      npc = $urandom & 32'hFFFF_FFFC;
      tgt = $urandom & 32'hFFFF_FFFC;
      cycle(r, s, f, npc, b, tgt);
      checks++;
      if (bus.if_valid_o !== (mq.size() != 0) || bus.rom_ce_o !== mce || bus.rom_addr_o !== mpc ||
          (mq.size() != 0 && {bus.if_pc_o, bus.if_inst_o} !== mq[0])) begin
        errors++;
        $display("FAIL random %0d: valid=%b ce=%b addr=%h head=%h/%h, expected valid=%0d ce=%b addr=%h head=%h",
                 i, bus.if_valid_o, bus.rom_ce_o, bus.rom_addr_o, bus.if_pc_o, bus.if_inst_o,
                 mq.size() != 0, mce, mpc, (mq.size() != 0) ? mq[0] : 64'h0);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.stall_i = 1'b0; bus.flush_i = 1'b0; bus.new_pc_i = 32'h0;
    bus.branch_flag_i = 1'b0; bus.branch_target_address_i = 32'h0;
    test_reset();
    test_stream();
    test_stall();
    test_branch_full();
    test_branch_empty();
    test_branch_stalled();
    test_flush();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/inst_fetch.md
# inst_fetch

Instruction-fetch front end that sits between the ROM and the IF/ID pipeline register. It is the fetching side of the ROM port: it drives `rom_ce_o`/`rom_addr_o` and captures `rom_inst_i`, which the ROM returns combinationally in the same cycle. Fetched words go into a 2-entry prefetch queue, so fetch keeps running while ID stalls. It also handles branch redirect with the MIPS delay slot, and exception flush.

## Interface
- `RESET_PC`, 32'h0000_0000, PC fetched first after reset.
- `DEPTH`, 2, prefetch queue depth; fixed at 2, not otherwise supported.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset (`RstEnable`).
- `stall_i`  in  1  ID hold; when high, the queue head is not consumed.
- `flush_i`  in  1  exception flush, one-cycle pulse.
- `new_pc_i`  in  32  restart PC accompanying `flush_i`.
- `branch_flag_i`  in  1  branch/jump taken, from ID.
- `branch_target_address_i`  in  32  redirect target.
- `rom_ce_o`  out  1  ROM chip enable (`ChipEnable`/`ChipDisable`).
- `rom_addr_o`  out  32  byte address to ROM; always the current fetch PC.
- `rom_inst_i`  in  32  ROM data, valid in the same cycle as `rom_addr_o` when `rom_ce_o` is high.
- `if_valid_o`  out  1  queue head is valid.
- `if_pc_o`  out  32  PC of the queue head.
- `if_inst_o`  out  32  instruction at the queue head.

## Operation
- FSM states:
  - IDLE: entered by reset; `rom_ce_o`=0.
  - RUN: any edge with `rst`=0 moves IDLE→RUN. Only `rst` leaves RUN.
- Reset values: fetch PC=`RESET_PC`, `rom_ce_o`=0, queue count=0, `if_valid_o`=0, `if_pc_o`=0, `if_inst_o`=0 (`ZeroWord`).
- Pop occurs when `if_valid_o` && !`stall_i`.
- Push occurs when state=RUN && `rom_ce_o` && (count<2 || pop).
  - The pushed entry is {fetch PC, `rom_inst_i`}.
  - On push, fetch PC += 4, wrapping modulo 2^32.
- Count update: push and pop in the same cycle leaves count unchanged. Push into a full queue is impossible by definition.
- Outputs: `if_pc_o`/`if_inst_o` are the stored head entry (registered, not combinational from ROM). `if_valid_o` = (count != 0).
- Branch redirect is honored only when `branch_flag_i` && !`stall_i`; it is ignored while stalled.
  - count≥1: the head is popped as the delay slot. All remaining entries and any same-cycle push are discarded. Count becomes 0. Fetch PC := target.
  - count=0: this cycle's push is the delay slot and is kept, so count becomes 1. Fetch PC := target.
- Flush, when `flush_i`=1, has top priority over branch, push and pop.
  - Queue is cleared; no pop is issued.
  - Fetch PC := `new_pc_i`.
- Priority order: `rst` > `flush_i` > honored branch > normal push/pop.

## Timing
- Reset sampled at edge E0; `rst` low at E1 → `rom_ce_o`=1 after E1; first push at E2 → `if_valid_o`=1, `if_pc_o`=`RESET_PC` after E2.
- Steady state with no stall: one instruction per cycle. Latency is one cycle from address to `if_valid_o`.
- While stalled, the queue fills to 2 and the next PC holds. Fetch resumes in the same cycle that the stall drops.
- Branch/flush: the first target instruction appears at `if_*_o` one edge after the redirect edge.
- `rst` asserted mid-operation discards queue contents at that edge. There is no partial state.

## Structure
- Constants `RstEnable`, `ChipEnable`, `ChipDisable`, `ZeroWord`, `InstAddrBus` and `InstBus` come from the shared `defines.v`. Add `IfStateIdle`/`IfStateRun` there.
- One natural sub-module: `inst_fetch_q`, a 2-entry FIFO with push, pop and clear ports that exposes the head and count. PC/FSM logic stays in `inst_fetch`.

## Test plan
- Reset, then run with ROM words = address ^ 32'hA5A5_0000 → `if_pc_o` sequence 0,4,8,… starting E2; `if_inst_o` matches each address.
- Hold `stall_i` high for 4 cycles at PC 0x10 → count saturates at 2 (heads 0x10, 0x14); `rom_addr_o` holds 0x18. Release → 0x10, 0x14, 0x18 delivered on consecutive cycles with no gap or duplicate.
- Branch with count=2 (head 0x24, tail 0x28), target 0x100, no stall → 0x24 consumed; 0x28 dropped; next `if_pc_o`=0x100.
- Branch with count=0, target 0x200 → entry at the current PC is kept as the delay slot and delivered next, followed by 0x200.
- `branch_flag_i` high with `stall_i` high for 3 cycles, then low → redirect happens only on the unstalled cycle.
- `flush_i` together with `branch_flag_i`, `new_pc_i`=0x180 → queue empty; next `if_pc_o`=0x180. Reset asserted mid-stream → all outputs return to reset values one edge later.
